csw_tape_player: RTL
====================

Name: csw_tape_player

Overview:
Plays a CSW v1 (RLE) cassette image as a square-wave level on the CPC motherboard tape-input line, next to the internal cassette path that feeds the PPI port B bit 7.
- Upstream: a byte stream delivered by the ioctl download buffer through a valid/ready handshake.
- Downstream: the motherboard tape input, optionally OR'd with the physical TAPE_IN pin.
- Pulse timing comes from a fractional sample-rate divider on clk_sys.

Parameters:
- CLK_HZ, 64000000, clk_sys frequency in Hz.
- SAMPLE_HZ, 44100, CSW sample rate in Hz; one tick = one CSW sample.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk_sys
- start  in  1  one-cycle pulse; begins playback from the next stream byte
- motor  in  1  cassette motor relay; 0 freezes playback
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies in_data as the final file byte
- in_ready  out  1  player accepts in_data this cycle
- tape_out  out  1  cassette level
- playing  out  1  playback active
- error  out  1  sticky; bad header (option) or start while stream empty for more than 2^16 cycles

Behaviour:
- Reset values: tape_out=0, playing=0, in_ready=0, error=0, state IDLE, tick accumulator=0, count=0.
- Reset mid-operation aborts immediately. No partial byte is retained.
- Tick generator: 32-bit accumulator acc.
  - Each cycle with motor=1 and playing=1: acc+=SAMPLE_HZ.
  - If the result is >= CLK_HZ: subtract CLK_HZ and set tick_pend=1.
  - tick_pend is a one-deep latch, cleared when COUNT consumes it. A second tick while pending is dropped; this cannot occur because fetches take at most 6 cycles.
- Handshake:
  - A byte transfers on a cycle where in_valid & in_ready.
  - in_ready is registered and high only in FETCH, L0..L3 (and HDR with the option).
  - in_ready drops the cycle after a transfer.
  - in_valid low just stalls. tape_out holds and no tick is consumed.
- States:
  - IDLE: start -> playing=1, acc=0, go FETCH (or HDR with the option). start while playing is ignored.
  - FETCH: byte B accepted.
    - B!=0: count=B, go COUNT.
    - B==0: go L0.
    - Record in_last.
  - L0..L3: collect a 32-bit little-endian length, L0 = LSB.
    - Then count=length, go COUNT.
    - Length 0 is treated as 1.
    - in_last on any of these bytes aborts: go DONE, tape_out unchanged.
  - COUNT: on tick_pend, count-=1.
    - When count reaches 0, tape_out toggles on that same edge.
    - Then go DONE if last was recorded, else FETCH.
  - DONE: playing=0, in_ready=0, go IDLE. tape_out keeps its level.
- Pulse length: N samples = N*CLK_HZ/SAMPLE_HZ cycles ±1 cycle. Error does not accumulate.
- motor=0: the accumulator, tick_pend and count are frozen and the state holds. in_ready is still driven, so a pending fetch may complete. tape_out holds.
- The error watchdog counts only in FETCH/L0..L3 with in_valid=0 and motor=1. It resets on any transfer. At 65536 it sets error; playback continues stalled.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro CSW_HDR_PARSE_EN.
- Defined: after start, state HDR consumes exactly 32 header bytes (index 0..31), then goes to FETCH.
  - Byte 0x17 != 1 (major version) or byte 0x1B != 1 (RLE compression): error=1, go DONE.
  - Byte 0x1C bit0 loads tape_out as the initial polarity.
  - in_last during the header sets error and goes to DONE.
- Undefined: the stream starts directly with pulse data and the initial tape_out is 0. HDR does not exist.

Test Plan:
- SAMPLE_HZ=44100, bytes 0x03,0x05(last), motor=1 -> tape_out 0->1 after 4354±1 cycles, 1->0 after a further 7256±1 cycles; playing falls 1 cycle later.
- Bytes 0x00,0x10,0x27,0x00,0x00 then 0x01(last) -> first pulse lasts 10000 ticks (14512472±1 cycles), second 1 tick.
- motor dropped for 5000 cycles mid-pulse of byte 0x0A -> the toggle is delayed by exactly 5000 cycles; tape_out is stable throughout.
- in_valid held low 70000 cycles in FETCH -> error=1 at 65536 stall cycles; tape_out unchanged; playback resumes when data arrives.
- reset pulsed during COUNT -> next cycle tape_out=0, playing=0, in_ready=0; a subsequent start plays from the next byte.
- With CSW_HDR_PARSE_EN: header with 0x1B=2 -> error=1, playing=0 after byte 32. Valid header with 0x1C=1 -> tape_out=1 before the first pulse.

Source files
------------

// File: rtl/csw_tape_player.sv
// CSW v1 RLE tape player: turns a pulse-length byte stream into a tape level.
// Define CSW_HDR_PARSE_EN to parse the 32-byte CSW header before pulse data.
module csw_tape_player #(
   parameter int unsigned CLK_HZ    = 64000000,
   parameter int unsigned SAMPLE_HZ = 44100
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       start,
   input  logic       motor,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       tape_out,
   output logic       playing,
   output logic       error
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_L0,
      S_L1,
      S_L2,
      S_L3,
      S_COUNT,
      S_DONE
`ifdef CSW_HDR_PARSE_EN
      , S_HDR
`endif
   } state_t;

`ifdef CSW_HDR_PARSE_EN
   localparam state_t S_FIRST = S_HDR;
`else
   localparam state_t S_FIRST = S_FETCH;
`endif

   localparam logic [31:0] CLK32 = CLK_HZ;
   localparam logic [31:0] SR32  = SAMPLE_HZ;

   state_t      state;
   state_t      nxt;
   logic        rdy_nxt;
   logic [31:0] acc;
   logic [32:0] acc_sum;
   logic [31:0] acc_sub;
   logic        tick_pend;
   logic        tick_new;
   logic        consume;
   logic        count_end;
   logic [31:0] count;
   logic [23:0] len;
   logic [31:0] len_w;
   logic        last_rec;
   logic [16:0] wd;
   logic        wd_en;
   logic        xfer;
   logic        run;
   logic        fetching;
`ifdef CSW_HDR_PARSE_EN
   logic [4:0]  hdr_idx;
   logic        hdr_bad;
`endif

   assign xfer      = in_valid & in_ready;
   assign run       = motor & playing;
   assign acc_sum   = {1'b0, acc} + {1'b0, SR32};
   assign acc_sub   = acc_sum[31:0] - CLK32;
   assign tick_new  = run & (acc_sum >= {1'b0, CLK32});
   assign consume   = (state == S_COUNT) & run & tick_pend;
   assign count_end = consume & (count == 32'd1);
   assign len_w     = {in_data, len};
   assign fetching  = state inside {S_FETCH, S_L0, S_L1, S_L2, S_L3};
   assign wd_en     = fetching & ~in_valid & motor;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= S_IDLE;
         in_ready <= 1'b0;
      end else begin
         state    <= nxt;
         in_ready <= rdy_nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (start) nxt = S_FIRST;
         S_FETCH: if (xfer) nxt = (in_data != 8'd0) ? S_COUNT : S_L0;
         S_L0:    if (xfer) nxt = in_last ? S_DONE : S_L1;
         S_L1:    if (xfer) nxt = in_last ? S_DONE : S_L2;
         S_L2:    if (xfer) nxt = in_last ? S_DONE : S_L3;
         S_L3:    if (xfer) nxt = in_last ? S_DONE : S_COUNT;
         S_COUNT: if (count_end) nxt = last_rec ? S_DONE : S_FETCH;
         S_DONE:  nxt = S_IDLE;
`ifdef CSW_HDR_PARSE_EN
         S_HDR: begin
            if (xfer) begin
               if (in_last)
                  nxt = S_DONE;
               else if (hdr_idx == 5'd31)
                  nxt = hdr_bad ? S_DONE : S_FETCH;
            end
         end
`endif
         default: nxt = S_IDLE;
      endcase
   end

   // in_ready is registered, so it takes a one-cycle bubble after each byte
   always_comb begin
      rdy_nxt = 1'b0;
      unique case (nxt)
         S_FETCH, S_L0, S_L1, S_L2, S_L3: rdy_nxt = ~xfer;
`ifdef CSW_HDR_PARSE_EN
         S_HDR: rdy_nxt = ~xfer;
`endif
         default: rdy_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         acc       <= '0;
         tick_pend <= 1'b0;
         count     <= '0;
         len       <= '0;
         last_rec  <= 1'b0;
         wd        <= '0;
         tape_out  <= 1'b0;
         playing   <= 1'b0;
         error     <= 1'b0;
`ifdef CSW_HDR_PARSE_EN
         hdr_idx   <= '0;
         hdr_bad   <= 1'b0;
`endif
      end else begin
         if (run) acc <= tick_new ? acc_sub : acc_sum[31:0];
         tick_pend <= tick_new | (tick_pend & ~consume);

         if (state == S_IDLE || xfer) begin
            wd <= '0;
         end else if (wd_en) begin
            if (!wd[16]) wd <= wd + 17'd1;
            if (wd == 17'h0FFFF) error <= 1'b1;
         end

         unique case (state)
            S_IDLE: begin
               if (start) begin
                  playing   <= 1'b1;
                  acc       <= '0;
                  tick_pend <= 1'b0;
                  last_rec  <= 1'b0;
`ifdef CSW_HDR_PARSE_EN
                  hdr_idx   <= '0;
                  hdr_bad   <= 1'b0;
`endif
               end
            end
            S_FETCH: begin
               if (xfer) begin
                  last_rec <= in_last;
                  if (in_data != 8'd0) count <= {24'd0, in_data};
               end
            end
            S_L0: if (xfer) len[7:0]   <= in_data;
            S_L1: if (xfer) len[15:8]  <= in_data;
            S_L2: if (xfer) len[23:16] <= in_data;
            S_L3: if (xfer) count <= (len_w == 32'd0) ? 32'd1 : len_w;
            S_COUNT: begin
               if (consume) begin
                  count <= count - 32'd1;
                  if (count_end) tape_out <= ~tape_out;
               end
            end
            S_DONE: playing <= 1'b0;
`ifdef CSW_HDR_PARSE_EN
            S_HDR: begin
               if (xfer) begin
                  hdr_idx <= hdr_idx + 5'd1;
                  if (hdr_idx == 5'h17 && in_data != 8'd1) hdr_bad <= 1'b1;
                  if (hdr_idx == 5'h1B && in_data != 8'd1) hdr_bad <= 1'b1;
                  if (hdr_idx == 5'h1C) tape_out <= in_data[0];
                  if (in_last || (hdr_idx == 5'd31 && hdr_bad))
                     error <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
